mem_port_arbiter: RTL and testbench

Shares one single-ported word memory between the pipelined CPU's instruction-fetch port (I, read-only) and data port (D, read/write). Serializes accesses with a fixed-latency memory handshake. Returns per-port ready pulses and stall levels to the hazard unit. Sits between the CPU core and the memory model, replacing the two-port memory's internal stall logic.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter: word width, FSM states, port ids
// and the latched access descriptor.
package mem_arb_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef enum logic {PORT_I, PORT_D} port_e;

  typedef struct packed {
    port_e                 id;
    logic                  we;
    logic [WORD_SIZE-1:0]  addr;
    logic [WORD_SIZE-1:0]  wdata;
  } acc_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker: a lone requester always wins, a conflict goes
// to the port that was not granted last. Purely combinational.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_id,
  output logic gnt_vld
);

  always_comb begin
    gnt_vld = req_i | req_d;
    gnt_id  = PORT_I;
    if (req_i && req_d) begin
      gnt_id = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d) begin
      gnt_id = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch (I) and data (D) accesses onto one single-ported memory.
// One access per LATENCY+2 cycles; a waiting port sees stall until its ready pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  output logic                 i_stall,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 d_stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  acc_t                 r_acc;
  port_e                r_last;
  logic [WORD_SIZE-1:0] r_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;
  logic                 r_i_ready;
  logic                 r_d_ready;
  logic                 w_gnt_id;
  logic                 w_gnt_vld;
  port_e                w_gnt_port;

  rr_arbiter2 u_rr_arbiter2 (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (r_last),
    .gnt_id     (w_gnt_id),
    .gnt_vld    (w_gnt_vld)
  );

  assign w_gnt_port = port_e'(w_gnt_id);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_last    <= PORT_I;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_acc.id    <= w_gnt_port;
            r_acc.we    <= (w_gnt_port == PORT_D) && d_we;
            r_acc.addr  <= (w_gnt_port == PORT_D) ? d_addr : i_addr;
            r_acc.wdata <= d_wdata;
            r_last      <= w_gnt_port;
            r_cnt       <= CNT_W'(LATENCY - 1);
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (r_acc.id == PORT_I) begin
            r_i_rdata <= mem_rdata;
            r_i_ready <= 1'b1;
          end else begin
            // A D write completes without disturbing the last read value.
            if (!r_acc.we) begin
              r_d_rdata <= mem_rdata;
            end
            r_d_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_read  = ~r_acc.we;
        mem_write = r_acc.we;
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = r_acc.addr;
  assign mem_wdata = r_acc.wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign i_stall   = i_req & ~r_i_ready;
  assign d_stall   = d_req & ~r_d_ready;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LATENCY = 2 and a 64K-word memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_ready, i_stall;
  logic [15:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready, d_stall;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        mem_read, mem_write, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .d_stall   (d_stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  assign mem_rdata = mem_read ? mem[mem_addr] : 16'h0000;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one D access from the current cycle and waits for its ready pulse.
  task automatic run_d(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       output int n_wr, output int n_cyc);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    n_wr    = 0;
    n_cyc   = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_write) n_wr++;
      if (d_ready) begin
        n_cyc = k;
        d_req = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cd, ci, got, nw, nc;
    int order [4];
    int ts [4];

    for (int a = 0; a < 65536; a++) mem[a] = 16'(a);
    mem[16'h0023] = 16'h6000;

    // Reset held with both requesters active: nothing may leave the block.
    reset_n = 1'b0;
    i_req = 1'b1; i_addr = 16'h0023;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0080; d_wdata = 16'h1234;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_i_rdata", i_rdata, 16'h0000);
    chk("rst_d_rdata", d_rdata, 16'h0000);
    reset_n = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_strobe", {mem_read, mem_write}, 2'b00);

    // Lone fetch of 0x23.
    i_req = 1'b1; i_addr = 16'h0023;
    @(negedge clk);
    chk("fetch_busy", busy, 1);
    chk("fetch_rd1", mem_read, 1);
    chk("fetch_addr", mem_addr, 16'h0023);
    chk("fetch_stall", i_stall, 1);
    chk("fetch_no_wr", mem_write, 0);
    @(negedge clk);
    chk("fetch_rd2", mem_read, 1);
    chk("fetch_early_rdy", i_ready, 0);
    @(negedge clk);
    chk("fetch_ready", i_ready, 1);
    chk("fetch_rdata", i_rdata, 16'h6000);
    chk("fetch_stall_rdy", i_stall, 0);
    chk("fetch_rd_off", mem_read, 0);
    chk("fetch_no_d_rdy", d_ready, 0);
    i_req = 1'b0;
    @(negedge clk);
    chk("fetch_idle", busy, 0);
    chk("fetch_rdy_pulse", i_ready, 0);

    // Simultaneous requests: D wins the first conflict, I follows 4 cycles later.
    i_req = 1'b1; i_addr = 16'h0024;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0001;
    cd = -1; ci = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_ready) begin
        cd = k;
        chk("conf_d_rdata", d_rdata, 16'h0001);
        chk("conf_i_stall", i_stall, 1);
        d_req = 1'b0;
      end
      if (i_ready) begin
        ci = k;
        chk("conf_i_rdata", i_rdata, 16'h0024);
        i_req = 1'b0;
        break;
      end
    end
    chk("conf_d_cycle", cd, 2);
    chk("conf_gap", ci - cd, 4);

    // Both held continuously: grants alternate D, I, D, I.
    i_req = 1'b1; i_addr = 16'h0003;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002;
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      if (d_ready || i_ready) begin
        order[got] = d_ready ? 1 : 0;
        ts[got]    = k;
        got++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("rr_count", got, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), order[k], (k % 2 == 0) ? 1 : 0);
    chk("rr_period", ts[3] - ts[0], 12);
    chk("rr_d_rdata", d_rdata, 16'h0002);
    chk("rr_i_rdata", i_rdata, 16'h0003);

    // Write 0xBEEF to 0x80, then read it back.
    run_d(1'b1, 16'h0080, 16'hBEEF, nw, nc);
    chk("wr_strobes", nw, 2);
    chk("wr_latency", nc, 3);
    chk("wr_keep_rdata", d_rdata, 16'h0002);
    chk("wr_mem", mem[16'h0080], 16'hBEEF);
    run_d(1'b0, 16'h0080, 16'h0000, nw, nc);
    chk("rd_strobes", nw, 0);
    chk("rd_latency", nc, 3);
    chk("rd_rdata", d_rdata, 16'hBEEF);

    // Reset during an I access, then the same fetch re-issued.
    i_req = 1'b1; i_addr = 16'h0023;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_rd", mem_read, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", i_ready, 0);
    chk("mid_rst_rd", mem_read, 0);
    chk("mid_rst_i_rdata", i_rdata, 16'h0000);
    chk("mid_rst_d_rdata", d_rdata, 16'h0000);
    reset_n = 1'b1;
    nc = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (i_ready) begin
        nc = k;
        break;
      end
    end
    chk("reissue_latency", nc, 2);
    chk("reissue_rdata", i_rdata, 16'h6000);
    i_req = 1'b0;
    @(negedge clk);
    chk("reissue_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
